// File: rtl/order_sequencer_if.sv
// Bundle of handshake, decode and status signals between the order sequencer
// and its memory / decode / arithmetic neighbours.
interface order_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              mem_ack;
  logic [ADDR_W-1:0] order_addr;
  logic              c10;
  logic              c22;
  logic              c25;
  logic              acc_sign;
  logic              exec_done;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              order_load;
  logic              exec_start;
  logic              order_stage;
  logic              halted;
  logic              fault;

  modport master (
    input  start, mem_ack, order_addr, c10, c22, c25, acc_sign, exec_done,
    output mem_req, mem_addr, order_load, exec_start, order_stage, halted, fault
  );

  modport slave (
    output start, mem_ack, order_addr, c10, c22, c25, acc_sign, exec_done,
    input  mem_req, mem_addr, order_load, exec_start, order_stage, halted, fault
  );
endinterface

// File: rtl/order_sequencer.sv
// Order sequencer: fetches orders from the sequence control tank address,
// resolves conditional jumps, and hands other orders to the arithmetic unit.
module order_sequencer #(
  parameter int ADDR_W       = 10,
  parameter int EXEC_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  order_sequencer_if.master bus
);
  localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WAIT   = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sct_q, sct_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic              jump_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sct_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sct_q   <= sct_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // E takes precedence over G when both decode lines are raised.
  assign jump_taken = bus.c25 ? ~bus.acc_sign : (bus.c10 & bus.acc_sign);

  always_comb begin
    state_d = state_q;
    sct_d   = sct_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      IDLE, STOP: begin
        if (bus.start) begin
          sct_d   = '0;
          fault_d = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.mem_ack) state_d = DECODE;
      end
      DECODE: begin
        if (bus.c22) begin
          state_d = STOP;
        end else if (bus.c25 || bus.c10) begin
          sct_d   = jump_taken ? bus.order_addr : sct_q + ADDR_W'(1);
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.exec_done) begin
          sct_d   = sct_q + ADDR_W'(1);
          state_d = FETCH;
        end else if (cnt_q == CNT_LAST) begin
          // SCT is left on the stalled order so it can be inspected.
          fault_d = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req     = (state_q == FETCH);
  assign bus.mem_addr    = sct_q;
  assign bus.order_load  = (state_q == FETCH) && bus.mem_ack;
  assign bus.exec_start  = (state_q == EXEC);
  assign bus.order_stage = (state_q == FETCH) || (state_q == DECODE);
  assign bus.halted      = (state_q == IDLE) || (state_q == STOP);
  assign bus.fault       = fault_q;
endmodule

// File: tb/tb_order_sequencer.sv
// Directed scoreboard bench for order_sequencer: expected fetch/exec/stop events
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_order_sequencer;
  localparam int AW = 10;
  localparam int TO = 8;

  localparam int K_FETCH = 0;
  localparam int K_EXEC  = 1;
  localparam int K_STOP  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  order_sequencer_if #(.ADDR_W(AW)) bus();

  order_sequencer #(.ADDR_W(AW), .EXEC_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic          flt;
  } ev_t;

  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_ev(input int kind, input int addr, input logic flt);
    ev_t e;
    e.kind = kind;
    e.addr = AW'(addr);
    e.flt  = flt;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d addr %0d expected no event", kind, bus.mem_addr);
    end else begin
      e = exp_q.pop_front();
      $display("event kind=%0d addr=%0d fault=%0b (expected kind=%0d addr=%0d)",
               kind, bus.mem_addr, bus.fault, e.kind, e.addr);
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_addr", 32'(bus.mem_addr), 32'(e.addr));
      if (kind == K_STOP) chk("stop_fault", 32'(bus.fault), 32'(e.flt));
    end
  endtask

  // Monitor: records every fetch load, exec strobe and entry into a halted state.
  initial begin
    logic prev_h;
    prev_h = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (bus.order_load && bus.exec_start) begin
          errors++;
          $display("FAIL load_exec_overlap: order_load=1 exec_start=1 expected not both");
        end
        if (bus.order_load) mon_event(K_FETCH);
        if (bus.exec_start) mon_event(K_EXEC);
        if (bus.halted && !prev_h) mon_event(K_STOP);
      end
      prev_h = bus.halted;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic fetch_decode(input logic k22, input logic k25, input logic k10,
                              input logic acc, input int oa);
    int n;
    n = 0;
    while (!bus.mem_req && n < 50) begin
      tick();
      n++;
    end
    if (!bus.mem_req) begin
      checks++;
      errors++;
      $display("FAIL fetch_wait: mem_req=0 expected 1 within 50 cycles");
    end
    bus.mem_ack    = 1'b1;
    bus.c22        = k22;
    bus.c25        = k25;
    bus.c10        = k10;
    bus.acc_sign   = acc;
    bus.order_addr = AW'(oa);
    tick();
    bus.mem_ack = 1'b0;
    tick();
    bus.c22        = 1'b0;
    bus.c25        = 1'b0;
    bus.c10        = 1'b0;
    bus.acc_sign   = 1'b0;
    bus.order_addr = '0;
  endtask

  task automatic finish_exec(input int dly, input logic ign);
    bus.exec_done = ign;
    tick();
    if (ign) chk("done_ignored_in_exec", 32'(bus.mem_req), 32'd0);
    chk("exec_start_one_cycle", 32'(bus.exec_start), 32'd0);
    bus.exec_done = 1'b0;
    repeat (dly) tick();
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
  endtask

  task automatic run_nj(input int a, input int dly, input logic ign);
    exp_ev(K_FETCH, a, 1'b0);
    exp_ev(K_EXEC, a, 1'b0);
    fetch_decode(1'b0, 1'b0, 1'b0, 1'b0, 0);
    finish_exec(dly, ign);
  endtask

  task automatic run_jump(input int a, input logic k25, input logic k10,
                          input logic acc, input int oa);
    exp_ev(K_FETCH, a, 1'b0);
    fetch_decode(1'b0, k25, k10, acc, oa);
  endtask

  task automatic check_reset_outs;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_order_load", 32'(bus.order_load), 32'd0);
    chk("rst_exec_start", 32'(bus.exec_start), 32'd0);
    chk("rst_order_stage", 32'(bus.order_stage), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd1);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
  endtask

  task automatic pulse_rst(input logic with_ack);
    bus.mem_ack = with_ack;
    rst = 1'b1;
    #1;
    check_reset_outs();
    @(negedge clk);
    #2;
    rst = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.exec_done = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    bus.start      = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.order_addr = '0;
    bus.c10        = 1'b0;
    bus.c22        = 1'b0;
    bus.c25        = 1'b0;
    bus.acc_sign   = 1'b0;
    bus.exec_done  = 1'b0;

    repeat (2) tick();
    check_reset_outs();
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_hold_halted", 32'(bus.halted), 32'd1);
    chk("idle_hold_mem_req", 32'(bus.mem_req), 32'd0);

    // Two plain orders, second with an exec_done glitch during EXEC.
    do_start();
    run_nj(0, 0, 1'b0);
    run_nj(1, 1, 1'b1);

    // Order at 2 with a stray start pulse while waiting: must not restart.
    exp_ev(K_FETCH, 2, 1'b0);
    exp_ev(K_EXEC, 2, 1'b0);
    fetch_decode(1'b0, 1'b0, 1'b0, 1'b0, 0);
    bus.exec_done = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;

    run_nj(3, 2, 1'b0);
    run_nj(4, 0, 1'b0);
    run_jump(5, 1'b1, 1'b0, 1'b0, 20);   // E taken -> 20
    run_jump(20, 1'b0, 1'b1, 1'b1, 5);   // G taken -> 5
    run_jump(5, 1'b1, 1'b0, 1'b1, 20);   // E not taken -> 6
    run_jump(6, 1'b1, 1'b1, 1'b1, 100);  // E wins over G, not taken -> 7
    run_jump(7, 1'b0, 1'b1, 1'b0, 200);  // G not taken -> 8

    // Stop order outranks a taken E.
    exp_ev(K_FETCH, 8, 1'b0);
    exp_ev(K_STOP, 8, 1'b0);
    fetch_decode(1'b1, 1'b1, 1'b0, 1'b0, 50);
    repeat (3) tick();
    chk("stop_hold_halted", 32'(bus.halted), 32'd1);
    chk("stop_hold_addr", 32'(bus.mem_addr), 32'd8);

    // Restart, jump to top address, wrap, then stop at 3.
    do_start();
    run_jump(0, 1'b1, 1'b0, 1'b0, 1023);
    run_nj(1023, 0, 1'b0);
    run_jump(0, 1'b1, 1'b0, 1'b0, 3);
    exp_ev(K_FETCH, 3, 1'b0);
    exp_ev(K_STOP, 3, 1'b0);
    fetch_decode(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("stop3_halted", 32'(bus.halted), 32'd1);
    chk("stop3_addr", 32'(bus.mem_addr), 32'd3);

    // Execution timeout.
    do_start();
    chk("restart_addr", 32'(bus.mem_addr), 32'd0);
    exp_ev(K_FETCH, 0, 1'b0);
    exp_ev(K_EXEC, 0, 1'b0);
    exp_ev(K_STOP, 0, 1'b1);
    fetch_decode(1'b0, 1'b0, 1'b0, 1'b0, 0);
    bus.exec_done = 1'b0;
    tick();
    n = 0;
    while (!bus.halted && n < 20) begin
      tick();
      n++;
    end
    chk("timeout_wait_cycles", 32'(n), 32'd8);
    chk("timeout_fault", 32'(bus.fault), 32'd1);
    chk("timeout_addr", 32'(bus.mem_addr), 32'd0);
    do_start();
    chk("start_clears_fault", 32'(bus.fault), 32'd0);

    // Reset while waiting for exec_done.
    exp_ev(K_FETCH, 0, 1'b0);
    exp_ev(K_EXEC, 0, 1'b0);
    fetch_decode(1'b0, 1'b0, 1'b0, 1'b0, 0);
    bus.exec_done = 1'b0;
    tick();
    pulse_rst(1'b0);
    repeat (2) tick();
    chk("post_rst_idle", 32'(bus.halted), 32'd1);
    do_start();
    run_nj(0, 0, 1'b0);

    // Reset in the middle of a fetch, with the ack arriving at the same time.
    chk("pre_rst_fetch", 32'(bus.mem_req), 32'd1);
    pulse_rst(1'b1);
    do_start();
    run_nj(0, 1, 1'b0);

    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
